video_plane_addrgen: RTL and testbench
======================================

Name: video_plane_addrgen

Overview:
Parametrised successor to the fixed-mode video address generator. Produces DRAM word addresses for up to PLANES linear bitplanes, each with its own base, and a shared line stride and line length. Planes are interleaved round-robin, one word per video_next. Sits between the video sync/mode-decode logic and the DRAM arbiter video port, and replaces per-mode hardwired address mangling with programmable linear fetch.

Parameters:
AW, 21, DRAM word address width
PLANES, 4, number of bitplanes (1..8)
XW, 8, width of the words-per-line counter
SW, 13, width of the line stride in words

Ports:
clk  in  1  28 MHz clock
rst  in  1  synchronous reset, active-high
frame_start  in  1  one-cycle frame start pulse (int_start)
line_start  in  1  one-cycle line start pulse
vpix  in  1  current line is in the visible pixel area
video_next  in  1  arbiter accepted the current address
cfg_base  in  PLANES*AW  per-plane base address; plane p occupies bits [p*AW +: AW]
cfg_stride  in  SW  words added to each plane pointer per line
cfg_wpl  in  XW  words per plane per line
cfg_plane_en  in  PLANES  plane enable mask
video_addr  out  AW  fetch address
video_plane  out  3  plane index of the current video_addr
addr_valid  out  1  video_addr is a live request
line_done  out  1  one-cycle pulse when the last word of a line is accepted

Behaviour:
- Reset values: video_addr=0, video_plane=0, addr_valid=0, line_done=0, state IDLE. All pointers and shadow config are zero.
- Shadow config: cfg_* is sampled into shadow registers on frame_start only. Mid-frame cfg changes have no effect until the next frame.
- On frame_start, each plane's line pointer lptr[p] is loaded with its base.
- FSM has three states: IDLE, FETCH, DONE.
  - IDLE/DONE to FETCH: on line_start & vpix, when shadow wpl != 0 and the shadow enable mask != 0. On that transition: x=0, plane = lowest enabled index. Next cycle, addr_valid=1 and video_addr=lptr[plane]+x.
  - FETCH, on video_next: advance to the next enabled plane in ascending order, wrapping to the lowest enabled plane. When the wrap occurs, x increments. video_addr updates on the cycle after video_next (registered, one-cycle latency).
  - FETCH, on video_next while at the last enabled plane with x==wpl-1: go to DONE. addr_valid=0, line_done=1 for one cycle, and every lptr[p] += stride.
  - line_start while in FETCH (line overrun): abandon the line. Apply the stride to all pointers and restart at x=0 in the same cycle. line_done is not pulsed.
- Ignored inputs and corner cases:
  - video_next while addr_valid=0 is ignored.
  - line_start with vpix=0 is ignored.
  - With wpl==0 or the mask==0, a visible line_start stays in or returns to IDLE. The stride is still applied so vertical position tracks.
- Arithmetic: address = lptr+x, modulo 2^AW, zero-extended. Stride add is also modulo 2^AW. Disabled planes' pointers advance as well.
- Simultaneous events:
  - frame_start and line_start in the same cycle: frame_start has priority. Pointers are reloaded with base and the line start is dropped.
  - frame_start during FETCH: addr_valid drops next cycle and the state goes to IDLE.
- Reset mid-line: state returns to IDLE immediately; no further requests.

Optional Feature:
Macro: VIDEO_PLANE_WRAP_EN.
- When defined, adds input cfg_wrap_mask (AW bits), shadowed on frame_start. Output address = (base[p] & ~mask) | ((lptr[p]+x) & mask), giving a power-of-two circular buffer for hardware vertical scroll.
- When undefined, the port is absent and addresses are plain linear.

Decomposition:
- Package video_pkg holds:
  - state encoding localparams ST_IDLE/ST_FETCH/ST_DONE;
  - default widths.
- Sub-module video_plane_ptr, one per plane:
  - holds lptr, with load-base, add-stride and optional wrap masking;
  - outputs the current address for a given x.
- The top module keeps the FSM and the priority encoder that selects the next enabled plane.

Test Plan:
1. PLANES=4, mask=4'b0101, base0=0x1000, base2=0x8000, wpl=2, stride=0x40. After frame_start and a visible line_start, with video_next every cycle, the sequence is 0x1000(p0), 0x8000(p2), 0x1001, 0x8001, then line_done. The next line starts at 0x1040.
2. wpl=0 with a visible line_start: addr_valid stays 0. After the line, lptr0 has advanced by the stride.
3. cfg_base changed mid-frame: the addresses produced are unchanged until the next frame_start, after which they use the new base.
4. frame_start and line_start asserted in the same cycle: pointers equal base, state is IDLE, no request is issued.
5. rst asserted during FETCH: addr_valid=0 on the next cycle, and video_addr=0.
6. (VIDEO_PLANE_WRAP_EN) base=0x2000, mask=0x00FF, lptr has reached 0x20FF: the next word fetched is 0x2000.

Source files
------------

// File: rtl/video_pkg.sv
// Shared state encoding and default widths for the video plane address generator.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_AW     = 21;
  localparam int DEF_PLANES = 4;
  localparam int DEF_XW     = 8;
  localparam int DEF_SW     = 13;

endpackage

// File: rtl/video_plane_ptr.sv
// Per-plane line pointer: loads base, steps by stride, emits the address for a word index.
// Optional VIDEO_PLANE_WRAP_EN confines addresses to a power-of-two window around base.
module video_plane_ptr
  import video_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int SW = DEF_SW,
  parameter int XW = DEF_XW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] base_i,
  input  logic [SW-1:0] stride_i,
  input  logic [XW-1:0] x_i,
`ifdef VIDEO_PLANE_WRAP_EN
  input  logic [AW-1:0] wrap_mask_i,
`endif
  output logic [AW-1:0] addr_o
);

  logic [AW-1:0] lptr_q, lptr_d;
  logic [AW-1:0] sum_s;
`ifdef VIDEO_PLANE_WRAP_EN
  logic [AW-1:0] base_q, base_d;
`endif

  // Address is formed from the next pointer value so the top can register it directly.
  always_comb begin
    lptr_d = lptr_q;
    if (load_i) begin
      lptr_d = base_i;
    end else if (step_i) begin
      lptr_d = lptr_q + AW'(stride_i);
    end else begin
      lptr_d = lptr_q;
    end
    sum_s = lptr_d + AW'(x_i);
`ifdef VIDEO_PLANE_WRAP_EN
    base_d = load_i ? base_i : base_q;
    addr_o = (base_d & ~wrap_mask_i) | (sum_s & wrap_mask_i);
`else
    addr_o = sum_s;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lptr_q <= {AW{1'b0}};
`ifdef VIDEO_PLANE_WRAP_EN
      base_q <= {AW{1'b0}};
`endif
    end else begin
      lptr_q <= lptr_d;
`ifdef VIDEO_PLANE_WRAP_EN
      base_q <= base_d;
`endif
    end
  end

endmodule

// File: rtl/video_plane_addrgen.sv
// Round-robin multi-plane DRAM fetch address generator with per-frame shadowed config.
// Optional VIDEO_PLANE_WRAP_EN adds cfg_wrap_mask for circular-buffer vertical scroll.
module video_plane_addrgen
  import video_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int PLANES = DEF_PLANES,
  parameter int XW     = DEF_XW,
  parameter int SW     = DEF_SW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 line_start,
  input  logic                 vpix,
  input  logic                 video_next,
  input  logic [PLANES*AW-1:0] cfg_base,
  input  logic [SW-1:0]        cfg_stride,
  input  logic [XW-1:0]        cfg_wpl,
  input  logic [PLANES-1:0]    cfg_plane_en,
`ifdef VIDEO_PLANE_WRAP_EN
  input  logic [AW-1:0]        cfg_wrap_mask,
`endif
  output logic [AW-1:0]        video_addr,
  output logic [2:0]           video_plane,
  output logic                 addr_valid,
  output logic                 line_done
);

  state_e            state_q, state_d;
  logic [SW-1:0]     stride_q;
  logic [XW-1:0]     wpl_q;
  logic [PLANES-1:0] en_q;
  logic [XW-1:0]     x_q, x_d;
  logic [2:0]        plane_q, plane_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              valid_q, valid_d, done_q, done_d;
  logic              load_s, step_s, wrap_s, start_ok_s;
  logic [2:0]        first_s, next_s;
  logic [AW-1:0]     paddr_s [PLANES];
`ifdef VIDEO_PLANE_WRAP_EN
  logic [AW-1:0]     wrap_mask_q;
`endif

  for (genvar p = 0; p < PLANES; p++) begin : g_ptr
    video_plane_ptr #(.AW(AW), .SW(SW), .XW(XW)) u_ptr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load_s),
      .step_i     (step_s),
      .base_i     (cfg_base[p*AW +: AW]),
      .stride_i   (stride_q),
      .x_i        (x_d),
`ifdef VIDEO_PLANE_WRAP_EN
      .wrap_mask_i(wrap_mask_q),
`endif
      .addr_o     (paddr_s[p])
    );
  end

  // Lowest enabled plane, and the next enabled plane above the current one (wrap if none).
  always_comb begin
    first_s = 3'd0;
    next_s  = 3'd0;
    wrap_s  = 1'b1;
    for (int p = PLANES - 1; p >= 0; p--) begin
      if (en_q[p]) begin
        first_s = 3'(p);
      end else begin
        first_s = first_s;
      end
    end
    next_s = first_s;
    for (int p = PLANES - 1; p >= 0; p--) begin
      if (en_q[p] && (3'(p) > plane_q)) begin
        next_s = 3'(p);
        wrap_s = 1'b0;
      end else begin
        next_s = next_s;
      end
    end
  end

  assign start_ok_s = (wpl_q != {XW{1'b0}}) && (en_q != {PLANES{1'b0}});

  // Line sequencing; frame_start outranks line_start, which outranks video_next.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    plane_d = plane_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    step_s  = 1'b0;
    if (frame_start) begin
      load_s  = 1'b1;
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else if (line_start && vpix) begin
      if (start_ok_s) begin
        step_s  = (state_q == ST_FETCH);
        state_d = ST_FETCH;
        x_d     = {XW{1'b0}};
        plane_d = first_s;
        valid_d = 1'b1;
      end else begin
        step_s  = 1'b1;
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    end else if ((state_q == ST_FETCH) && video_next && valid_q) begin
      if (wrap_s && (x_q == wpl_q - XW'(1))) begin
        state_d = ST_DONE;
        valid_d = 1'b0;
        done_d  = 1'b1;
        step_s  = 1'b1;
      end else begin
        plane_d = next_s;
        x_d     = wrap_s ? x_q + XW'(1) : x_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    addr_d = {AW{1'b0}};
    for (int p = 0; p < PLANES; p++) begin
      if (plane_d == 3'(p)) begin
        addr_d = paddr_s[p];
      end else begin
        addr_d = addr_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= {XW{1'b0}};
      plane_q  <= 3'd0;
      addr_q   <= {AW{1'b0}};
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      stride_q <= {SW{1'b0}};
      wpl_q    <= {XW{1'b0}};
      en_q     <= {PLANES{1'b0}};
`ifdef VIDEO_PLANE_WRAP_EN
      wrap_mask_q <= {AW{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      plane_q <= plane_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (frame_start) begin
        stride_q <= cfg_stride;
        wpl_q    <= cfg_wpl;
        en_q     <= cfg_plane_en;
`ifdef VIDEO_PLANE_WRAP_EN
        wrap_mask_q <= cfg_wrap_mask;
`endif
      end
    end
  end

  assign video_addr  = addr_q;
  assign video_plane = plane_q;
  assign addr_valid  = valid_q;
  assign line_done   = done_q;

endmodule

// File: tb/tb_video_plane_addrgen.sv
// Self-checking bench: transaction-level model of the line fetch order plus directed literal checks.
module tb_video_plane_addrgen;

  localparam int AW = 21;
  localparam int NP = 4;

  logic            clk = 1'b0;
  logic            rst, frame_start, line_start, vpix, video_next;
  logic [NP*AW-1:0] cfg_base;
  logic [12:0]     cfg_stride;
  logic [7:0]      cfg_wpl;
  logic [NP-1:0]   cfg_plane_en;
`ifdef VIDEO_PLANE_WRAP_EN
  logic [AW-1:0]   cfg_wrap_mask;
`endif
  logic [AW-1:0]   video_addr;
  logic [2:0]      video_plane;
  logic            addr_valid, line_done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  video_plane_addrgen dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .line_start(line_start),
    .vpix(vpix), .video_next(video_next), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_wpl(cfg_wpl), .cfg_plane_en(cfg_plane_en),
`ifdef VIDEO_PLANE_WRAP_EN
    .cfg_wrap_mask(cfg_wrap_mask),
`endif
    .video_addr(video_addr), .video_plane(video_plane),
    .addr_valid(addr_valid), .line_done(line_done)
  );

  // Model: pointers, shadow config and the queue of words still owed for the current line.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    plane;
    logic          last;
  } req_t;

  logic [AW-1:0] m_lptr [NP];
  logic [AW-1:0] m_base [NP];
  logic [12:0]   m_stride;
  logic [7:0]    m_wpl;
  logic [NP-1:0] m_en;
  logic [AW-1:0] m_wmask;
  req_t          q[$];
  bit            done_pend;
  logic [AW-1:0] acc_log[$];

  function automatic logic [AW-1:0] m_addr(int p, int x);
    logic [AW-1:0] s;
    s = AW'(m_lptr[p] + AW'(x));
`ifdef VIDEO_PLANE_WRAP_EN
    s = (m_base[p] & ~m_wmask) | (s & m_wmask);
`endif
    return s;
  endfunction

  task automatic m_step();
    for (int p = 0; p < NP; p++) m_lptr[p] = AW'(m_lptr[p] + AW'(m_stride));
  endtask

  task automatic m_push_line();
    req_t r;
    for (int x = 0; x < int'(m_wpl); x++)
      for (int p = 0; p < NP; p++)
        if (m_en[p]) begin
          r.addr = m_addr(p, x);
          r.plane = 3'(p);
          r.last = 1'b0;
          q.push_back(r);
        end
    q[q.size()-1].last = 1'b1;
  endtask

  // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (addr_valid !== (q.size() != 0)) begin
        fails++;
        $display("FAIL cmp_valid: got %0b want %0b at %0t", addr_valid, (q.size() != 0), $time);
      end
      if (addr_valid === 1'b1 && q.size() != 0) begin
        tests++;
        if (video_addr !== q[0].addr || video_plane !== q[0].plane) begin
          fails++;
          $display("FAIL cmp_addr: got %h/p%0d want %h/p%0d at %0t",
                   video_addr, video_plane, q[0].addr, q[0].plane, $time);
        end
      end
      tests++;
      if (line_done !== done_pend) begin
        fails++;
        $display("FAIL cmp_done: got %0b want %0b at %0t", line_done, done_pend, $time);
      end
      if (line_done === 1'b1) done_cnt++;
      if (addr_valid === 1'b1 && video_next && !rst && !frame_start && !(line_start && vpix))
        acc_log.push_back(video_addr);
    end
    done_pend = 1'b0;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin m_lptr[p] = '0; m_base[p] = '0; end
      m_stride = '0; m_wpl = '0; m_en = '0; m_wmask = '0;
      q.delete();
    end else if (frame_start) begin
      for (int p = 0; p < NP; p++) begin
        m_base[p] = cfg_base[p*AW +: AW];
        m_lptr[p] = m_base[p];
      end
      m_stride = cfg_stride; m_wpl = cfg_wpl; m_en = cfg_plane_en;
`ifdef VIDEO_PLANE_WRAP_EN
      m_wmask = cfg_wrap_mask;
`endif
      q.delete();
    end else if (line_start && vpix) begin
      if (q.size() != 0) begin
        m_step();
        q.delete();
      end else if (m_wpl == 8'd0 || m_en == '0) begin
        m_step();
      end
      if (m_wpl != 8'd0 && m_en != '0) m_push_line();
    end else if (video_next && q.size() != 0) begin
      if (q[0].last) begin
        m_step();
        done_pend = 1'b1;
      end
      void'(q.pop_front());
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
  endtask

  task automatic pulse_line();
    line_start = 1'b1; vpix = 1'b1; tick(1); line_start = 1'b0;
  endtask

  task automatic set_base(int p, logic [AW-1:0] v);
    cfg_base[p*AW +: AW] = v;
  endtask

  int dc;

  initial begin
    rst = 1'b1; frame_start = 1'b0; line_start = 1'b0; vpix = 1'b0; video_next = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_wpl = '0; cfg_plane_en = '0;
`ifdef VIDEO_PLANE_WRAP_EN
    cfg_wrap_mask = 21'h1FFFFF;
`endif
    tick(3);
    rst = 1'b0;
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_addr", 32'(video_addr), 32'd0);
    chk("rst_plane", 32'(video_plane), 32'd0);
    chk("rst_done", 32'(line_done), 32'd0);
    chk_en = 1'b1;

    // Two interleaved planes, two words each.
    set_base(0, 21'h1000); set_base(1, 21'h3000); set_base(2, 21'h8000); set_base(3, 21'h5000);
    cfg_plane_en = 4'b0101; cfg_wpl = 8'd2; cfg_stride = 13'h40;
    pulse_frame();
    video_next = 1'b1; acc_log.delete(); dc = done_cnt;
    pulse_line(); tick(8);
    chk("t1_cnt", 32'(acc_log.size()), 32'd4);
    chk("t1_w0", 32'(acc_log[0]), 32'h1000);
    chk("t1_w1", 32'(acc_log[1]), 32'h8000);
    chk("t1_w2", 32'(acc_log[2]), 32'h1001);
    chk("t1_w3", 32'(acc_log[3]), 32'h8001);
    chk("t1_done", 32'(done_cnt - dc), 32'd1);
    pulse_line(); tick(8);
    chk("t1_next", 32'(acc_log[4]), 32'h1040);
    chk("t1_next2", 32'(acc_log[5]), 32'h8040);

    // Zero words per line: no requests, stride still applied.
    cfg_wpl = 8'd0; pulse_frame(); acc_log.delete();
    pulse_line(); tick(4);
    chk("t2_none", 32'(acc_log.size()), 32'd0);
    chk("t2_lptr0", 32'(m_lptr[0]), 32'h1040);
    cfg_wpl = 8'd2; cfg_plane_en = 4'b0000; pulse_frame();
    pulse_line(); tick(4);
    chk("t2_mask0", 32'(acc_log.size()), 32'd0);

    // Mid-frame base change is invisible until the next frame.
    cfg_plane_en = 4'b0001; cfg_wpl = 8'd1; cfg_stride = 13'h10;
    pulse_frame(); acc_log.delete();
    pulse_line(); tick(4);
    set_base(0, 21'h4000);
    pulse_line(); tick(4);
    pulse_frame();
    pulse_line(); tick(4);
    chk("t3_a", 32'(acc_log[0]), 32'h1000);
    chk("t3_b", 32'(acc_log[1]), 32'h1010);
    chk("t3_c", 32'(acc_log[2]), 32'h4000);

    // frame_start and line_start together: the line is dropped.
    acc_log.delete();
    frame_start = 1'b1; line_start = 1'b1; vpix = 1'b1; tick(1);
    frame_start = 1'b0; line_start = 1'b0;
    tick(4);
    chk("t4_none", 32'(acc_log.size()), 32'd0);
    chk("t4_valid", 32'(addr_valid), 32'd0);
    pulse_line(); tick(4);
    chk("t4_base", 32'(acc_log[0]), 32'h4000);

    // Reset in the middle of a line.
    video_next = 1'b0;
    pulse_line(); tick(2);
    chk("t5_pre_valid", 32'(addr_valid), 32'd1);
    chk("t5_pre_addr", 32'(video_addr), 32'h4010);
    rst = 1'b1; tick(1);
    chk("t5_valid", 32'(addr_valid), 32'd0);
    chk("t5_addr", 32'(video_addr), 32'd0);
    rst = 1'b0; tick(2);

    // Line overrun: restart with stride applied, no line_done.
    set_base(0, 21'h100); cfg_plane_en = 4'b0001; cfg_wpl = 8'd3; cfg_stride = 13'h20;
    pulse_frame(); acc_log.delete(); dc = done_cnt;
    pulse_line(); tick(2);
    video_next = 1'b1; tick(1); video_next = 1'b0;
    pulse_line();
    chk("t7_restart", 32'(video_addr), 32'h120);
    chk("t7_nodone", 32'(done_cnt - dc), 32'd0);
    video_next = 1'b1; tick(6);
    chk("t7_cnt", 32'(acc_log.size()), 32'd4);
    chk("t7_last", 32'(acc_log[3]), 32'h122);

    // Three planes with stalls on video_next.
    set_base(1, 21'h10); set_base(2, 21'h20); set_base(3, 21'h30);
    cfg_plane_en = 4'b1110; cfg_wpl = 8'd2; cfg_stride = 13'h100;
    video_next = 1'b0; pulse_frame(); acc_log.delete();
    pulse_line();
    for (int i = 0; i < 16; i++) begin video_next = ~video_next; tick(1); end
    video_next = 1'b0; tick(2);
    chk("t8_cnt", 32'(acc_log.size()), 32'd6);
    chk("t8_w0", 32'(acc_log[0]), 32'h10);
    chk("t8_w3", 32'(acc_log[3]), 32'h11);
    chk("t8_w5", 32'(acc_log[5]), 32'h31);

`ifdef VIDEO_PLANE_WRAP_EN
    // Circular window of 256 words.
    set_base(0, 21'h2000); cfg_plane_en = 4'b0001; cfg_wpl = 8'd2; cfg_stride = 13'hFF;
    cfg_wrap_mask = 21'h0000FF;
    pulse_frame(); acc_log.delete(); video_next = 1'b1;
    pulse_line(); tick(6);
    pulse_line(); tick(6);
    chk("t6_w2", 32'(acc_log[2]), 32'h20FF);
    chk("t6_wrap", 32'(acc_log[3]), 32'h2000);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
